// File: rtl/sb_tx_serializer_if.sv
//------------------------------------------------------------------------------
// Module  : sb_tx_serializer_if
// Brief   : Packet handshake and sideband TX tile signals of the serializer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sb_tx_serializer_if #(
    parameter int PKT_BITS = 64
);
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_valid;
    logic                pkt_ready;
    logic                sb_txdata;
    logic                sb_txclk_en;
    logic                busy;
    logic                pkt_done;

    modport master (
        output pkt_data, pkt_valid,
        input  pkt_ready, sb_txdata, sb_txclk_en, busy, pkt_done
    );

    modport slave (
        input  pkt_data, pkt_valid,
        output pkt_ready, sb_txdata, sb_txclk_en, busy, pkt_done
    );
endinterface

`default_nettype wire

// File: rtl/sb_tx_serializer.sv
//------------------------------------------------------------------------------
// Module  : sb_tx_serializer
// Brief   : Sideband TX serializer, LSB first, gated clock enable, idle gap.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sb_tx_serializer #(
    parameter int PKT_BITS = 64,
    parameter int GAP_UI   = 32,
    parameter int CNT_W    = 7
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sb_tx_serializer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_PKT_LAST = CNT_W'(PKT_BITS - 1);
    localparam logic [CNT_W-1:0] c_DONE_AT  = CNT_W'(PKT_BITS - 2);
    localparam logic [CNT_W-1:0] c_GAP_LAST = CNT_W'(GAP_UI - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    state_t              state_q;
    logic [PKT_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                txdata_q;
    logic                clk_en_q;
    logic                busy_q;
    logic                done_q;

    logic                w_ready;
    logic                w_accept;

    assign w_ready  = !reset && ((state_q == S_IDLE) ||
                                 ((state_q == S_GAP) && (cnt_q == c_GAP_LAST)));
    assign w_accept = w_ready && bus.pkt_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            txdata_q <= 1'b0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            txdata_q <= 1'b0;
            clk_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_SEND: begin
                    if (cnt_q == c_PKT_LAST) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else begin
                        txdata_q <= shreg_q[0];
                        clk_en_q <= 1'b1;
                        shreg_q  <= shreg_q >> 1;
                        cnt_q    <= cnt_q + c_ONE;
                        done_q   <= (cnt_q == c_DONE_AT);
                    end
                end
                S_GAP: begin
                    if (cnt_q == c_GAP_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Bit 0 goes straight to the output register; the rest shift out of shreg_q.
            if (w_accept) begin
                state_q  <= S_SEND;
                shreg_q  <= bus.pkt_data >> 1;
                txdata_q <= bus.pkt_data[0];
                clk_en_q <= 1'b1;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                done_q   <= 1'b0;
            end
        end
    end

    assign bus.pkt_ready   = w_ready;
    assign bus.sb_txdata   = txdata_q;
    assign bus.sb_txclk_en = clk_en_q;
    assign bus.busy        = busy_q;
    assign bus.pkt_done    = done_q;

endmodule

`default_nettype wire
